// File: rtl/tinycpu_p.sv
// rtl/tinycpu_p.sv - parametrised stack-machine core with memory, I/O handshakes and sticky faults
module tinycpu_p #(
    parameter int DW    = 16,
    parameter int AW    = 12,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    output logic [AW-1:0]          mem_addr,
    input  logic [DW-1:0]          mem_rdata,
    output logic [DW-1:0]          mem_wdata,
    output logic                   mem_we,
    input  logic [DW-1:0]          in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DW-1:0]          out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             cs,
    output logic [AW-1:0]          pc,
    output logic [DW-1:0]          ir,
    output logic [DW-1:0]          qtop,
    output logic [$clog2(DEPTH):0] sp,
    output logic [1:0]             fault
);
    localparam int LW  = $clog2(DEPTH);
    localparam int SPW = LW + 1;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_PUSH  = 4'h2;
    localparam logic [3:0] OP_POP   = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_JZ    = 4'h5;
    localparam logic [3:0] OP_JNZ   = 4'h6;
    localparam logic [3:0] OP_IN    = 4'h8;
    localparam logic [3:0] OP_OUT   = 4'h9;
    localparam logic [3:0] OP_ALU   = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCHA = 3'd1,
        S_FETCHB = 3'd2,
        S_EXECA  = 3'd3,
        S_EXECB  = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    state_t         state;
    logic [DW-1:0]  stk [DEPTH];

    logic [3:0]     opcode;
    logic [AW-1:0]  operand;
    logic [DW-1:0]  imm;
    logic [4:0]     func;
    logic [LW-1:0]  i_top, i_nxt, i_new;
    logic [DW-1:0]  top_v, nxt_v;
    logic           empty, full, two;
    logic           func_ok;
    logic [1:0]     fcode;
    logic [DW-1:0]  alu_r;
    logic           out_stall, out_load;

    assign opcode  = ir[DW-1:DW-4];
    assign operand = ir[AW-1:0];
    assign imm     = {{(DW-AW){ir[AW-1]}}, ir[AW-1:0]};
    assign func    = ir[4:0];

    // stack slots: the top lives at sp-1, the next entry at sp-2, a push lands at sp
    assign i_top = LW'(sp - SPW'(1));
    assign i_nxt = LW'(sp - SPW'(2));
    assign i_new = LW'(sp);
    assign top_v = stk[i_top];
    assign nxt_v = stk[i_nxt];

    assign empty = (sp == '0);
    assign full  = (sp == SPW'(DEPTH));
    assign two   = (sp >= SPW'(2));

    assign qtop  = empty ? '0 : top_v;
    assign cs    = state;

    // unary codes 00-03, binary codes 10-17; everything else is illegal
    assign func_ok = func[4] ? (func[3] == 1'b0) : (func[3:2] == 2'b00);

    // fault code the current instruction would raise if executed this cycle
    always_comb begin
        fcode = 2'd0;
        case (opcode)
            OP_PUSHI, OP_PUSH, OP_IN: if (full) fcode = 2'd1;
            OP_POP, OP_JZ, OP_JNZ, OP_OUT: if (empty) fcode = 2'd2;
            OP_ALU: begin
                if (!func_ok)
                    fcode = 2'd3;
                else if (func[4] ? !two : empty)
                    fcode = 2'd2;
            end
            default: fcode = 2'd0;
        endcase
    end

    // ALU result: unary ops act on top, binary ops compute next op top
    always_comb begin
        alu_r = '0;
        case (func)
            5'h00: alu_r = ~top_v;
            5'h01: alu_r = -top_v;
            5'h02: alu_r = top_v + DW'(1);
            5'h03: alu_r = top_v - DW'(1);
            5'h10: alu_r = nxt_v + top_v;
            5'h11: alu_r = nxt_v - top_v;
            5'h12: alu_r = nxt_v & top_v;
            5'h13: alu_r = nxt_v | top_v;
            5'h14: alu_r = nxt_v ^ top_v;
            5'h15: alu_r = nxt_v << top_v[4:0];
            5'h16: alu_r = {{(DW-1){1'b0}}, (nxt_v == top_v)};
            5'h17: alu_r = {{(DW-1){1'b0}}, ($signed(nxt_v) < $signed(top_v))};
            default: alu_r = '0;
        endcase
    end

    // memory address follows the state: operand during execute, pc otherwise
    assign mem_addr  = (state == S_EXECA) ? operand : pc;
    assign mem_wdata = qtop;
    assign mem_we    = (state == S_EXECA) && (opcode == OP_POP) && (fcode == 2'd0);
    assign in_ready  = (state == S_EXECA) && (opcode == OP_IN) && (fcode == 2'd0);

    assign out_stall = out_valid && !out_ready;
    assign out_load  = (state == S_EXECA) && (opcode == OP_OUT) && (fcode == 2'd0) && !out_stall;

    // control FSM, stack and output register; a faulting instruction changes only fault/state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            sp        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            fault     <= 2'd0;
        end else begin
            if (out_load) begin
                out_data  <= top_v;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (run)
                        state <= S_FETCHA;
                end
                S_FETCHA: begin
                    pc    <= pc + AW'(1);
                    state <= S_FETCHB;
                end
                S_FETCHB: begin
                    ir    <= mem_rdata;
                    state <= S_EXECA;
                end
                S_EXECA: begin
                    if (fcode != 2'd0) begin
                        fault <= fcode;
                        state <= S_FAULT;
                    end else begin
                        state <= S_FETCHA;
                        case (opcode)
                            OP_PUSHI: begin
                                stk[i_new] <= imm;
                                sp         <= sp + SPW'(1);
                            end
                            OP_PUSH: state <= S_EXECB;
                            OP_POP:  sp <= sp - SPW'(1);
                            OP_JMP:  pc <= operand;
                            OP_JZ: begin
                                if (top_v == '0)
                                    pc <= operand;
                                sp <= sp - SPW'(1);
                            end
                            OP_JNZ: begin
                                if (top_v != '0)
                                    pc <= operand;
                                sp <= sp - SPW'(1);
                            end
                            OP_IN: begin
                                if (in_valid) begin
                                    stk[i_new] <= in_data;
                                    sp         <= sp + SPW'(1);
                                end else begin
                                    state <= S_EXECA;
                                end
                            end
                            OP_OUT: begin
                                if (out_stall)
                                    state <= S_EXECA;
                                else
                                    sp <= sp - SPW'(1);
                            end
                            OP_ALU: begin
                                if (func[4]) begin
                                    stk[i_nxt] <= alu_r;
                                    sp         <= sp - SPW'(1);
                                end else begin
                                    stk[i_top] <= alu_r;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_EXECB: begin
                    stk[i_new] <= mem_rdata;
                    sp         <= sp + SPW'(1);
                    state      <= S_FETCHA;
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
